// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and helpers
package uart_pkg;

  // Baud ticks per bit, common with the 16x baud generator.
  localparam int RESOLUTION = 16;

  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_SB_TICK   = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } rx_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - line-side inputs and core-side outputs of the receiver
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
) ();

  logic                 baudTick;
  logic                 rx;
  logic [DATA_BITS-1:0] dataOut;
  logic                 rxDone;
  logic                 frameError;

  // Parent/stimulus side: supplies ticks and the serial line, consumes words.
  modport master (
    output baudTick, rx,
    input  dataOut, rxDone, frameError
  );

  // Receiver side.
  modport slave (
    input  baudTick, rx,
    output dataOut, rxDone, frameError
  );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rx metastability synchroniser with falling-edge detect
module uart_rx_sync (
  input  logic clk,
  input  logic rstN,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two-flop synchroniser plus a history flop; preset high so reset release looks idle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s_o      = sync_q;
  assign fall_edge_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver, mid-bit sampling, LSB first
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int SB_TICK   = DEF_SB_TICK
) (
  input logic      clk,
  input logic      rstN,
  uart_rx_if.slave bus
);

  localparam int TICK_W = $clog2(max_int(RESOLUTION, SB_TICK));
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(RESOLUTION / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RESOLUTION - 1);
  localparam logic [TICK_W-1:0] TICK_STOP = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic rx_s;
  logic fall_edge;

  rx_state_t             state_q,  state_d;
  logic [TICK_W-1:0]     tick_q,   tick_d;
  logic [BIT_W-1:0]      bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0]  shift_q,  shift_d;
  logic [DATA_BITS-1:0]  data_q,   data_d;
  logic                  done_q,   done_d;
  logic                  ferr_q,   ferr_d;

  uart_rx_sync u_sync (
    .clk         (clk),
    .rstN        (rstN),
    .rx_i        (bus.rx),
    .rx_s_o      (rx_s),
    .fall_edge_o (fall_edge)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      done_q   <= done_d;
      ferr_q   <= ferr_d;
    end
  end

  // Frame sequencing: arm on a falling edge, confirm at mid start bit, sample mid-bit.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    ferr_d   = ferr_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_edge) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (bus.baudTick) begin
          if (tick_q == TICK_MID) begin
            if (!rx_s) begin
              state_d  = DATA;
              tick_d   = '0;
              bitcnt_d = '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      DATA: begin
        if (bus.baudTick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bitcnt_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bitcnt_d = bitcnt_q + BIT_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      STOP: begin
        if (bus.baudTick) begin
          if (tick_q == TICK_STOP) begin
            // Returning to IDLE here lets a start edge right after the stop bit be caught.
            data_d  = shift_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dataOut    = data_q;
  assign bus.rxDone     = done_q;
  assign bus.frameError = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
  import uart_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLK  = RESOLUTION * TICK_DIV;

  logic clk = 1'b0;
  logic rstN;
  logic rx8 = 1'b1;
  logic rx7 = 1'b1;
  logic tick = 1'b0;
  int   cyc = 0;

  int n_assert = 0;
  int n_fail   = 0;

  uart_rx_if #(.DATA_BITS(8)) bus8 ();
  uart_rx_if #(.DATA_BITS(7)) bus7 ();

  assign bus8.rx       = rx8;
  assign bus7.rx       = rx7;
  assign bus8.baudTick = tick;
  assign bus7.baudTick = tick;

  uart_rx #(.DATA_BITS(8), .SB_TICK(16)) dut8 (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus8.slave)
  );

  uart_rx #(.DATA_BITS(7), .SB_TICK(32)) dut7 (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus7.slave)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Baud tick: one clk high every TICK_DIV clks, updated on the falling edge.
  initial begin
    int div_cnt;
    div_cnt = 0;
    forever begin
      @(negedge clk);
      if (div_cnt == TICK_DIV - 1) begin
        div_cnt = 0;
        tick = 1'b1;
      end else begin
        div_cnt = div_cnt + 1;
        tick = 1'b0;
      end
    end
  end

  // Capture of every rxDone pulse.
  int         done8 = 0, done7 = 0, wide8 = 0, wide7 = 0;
  logic       prev8 = 1'b0, prev7 = 1'b0;
  logic [7:0] data8_q[$];
  logic       ferr8_q[$];
  int         cyc8_q[$];
  logic [6:0] last_data7;
  logic       last_ferr7;
  int         last_cyc7;

  always @(negedge clk) begin
    if (bus8.rxDone) begin
      done8 = done8 + 1;
      data8_q.push_back(bus8.dataOut);
      ferr8_q.push_back(bus8.frameError);
      cyc8_q.push_back(cyc);
      if (prev8) wide8 = wide8 + 1;
    end
    prev8 = bus8.rxDone;
    if (bus7.rxDone) begin
      done7 = done7 + 1;
      last_data7 = bus7.dataOut;
      last_ferr7 = bus7.frameError;
      last_cyc7  = cyc;
      if (prev7) wide7 = wide7 + 1;
    end
    prev7 = bus7.rxDone;
  end

  int start_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel7, input logic v);
    if (sel7) rx7 = v;
    else      rx8 = v;
  endtask

  // Start bit, LSB-first data, then the stop level held for stop_ticks baud ticks.
  task automatic send_frame(input bit sel7, input logic [8:0] data, input int nbits,
                            input logic stop_val, input int stop_ticks);
    drive(sel7, 1'b0);
    start_cyc = cyc;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      drive(sel7, data[i]);
      repeat (BIT_CLK) @(negedge clk);
    end
    drive(sel7, stop_val);
    repeat (stop_ticks * TICK_DIV) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BIT_CLK) @(negedge clk);
  endtask

  initial begin
    int lat;
    rstN = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_rxdone8", bus8.rxDone, 1'b0);
    chk("reset_data8", bus8.dataOut, 8'h00);
    chk("reset_ferr8", bus8.frameError, 1'b0);
    chk("reset_data7", bus7.dataOut, 7'h00);
    rstN = 1'b1;
    idle_bits(2);
    chk("no_start_after_reset", done8, 0);

    // 1: single 0xA5 frame and its latency (152 ticks after edge detect).
    send_frame(1'b0, 9'h0A5, 8, 1'b1, 16);
    lat = cyc8_q.size() > 0 ? cyc8_q[0] - start_cyc : 0;
    chk("t1_count", done8, 1);
    chk("t1_data", data8_q.size() > 0 ? data8_q[0] : 8'hxx, 8'hA5);
    chk("t1_ferr", ferr8_q.size() > 0 ? ferr8_q[0] : 1'bx, 1'b0);
    chk("t1_latency_in_window", (lat >= 604 && lat <= 616), 1'b1);
    idle_bits(1);
    chk("t1_data_held", bus8.dataOut, 8'hA5);

    // 2: 0x00 then 0xFF with no idle gap; frames exactly 10 bit times apart.
    send_frame(1'b0, 9'h000, 8, 1'b1, 16);
    send_frame(1'b0, 9'h0FF, 8, 1'b1, 16);
    chk("t2_count", done8, 3);
    chk("t2_data0", data8_q.size() > 2 ? data8_q[1] : 8'hxx, 8'h00);
    chk("t2_data1", data8_q.size() > 2 ? data8_q[2] : 8'hxx, 8'hFF);
    chk("t2_ferr0", ferr8_q.size() > 2 ? ferr8_q[1] : 1'bx, 1'b0);
    chk("t2_ferr1", ferr8_q.size() > 2 ? ferr8_q[2] : 1'bx, 1'b0);
    chk("t2_spacing", cyc8_q.size() > 2 ? cyc8_q[2] - cyc8_q[1] : 0, 10 * BIT_CLK);
    idle_bits(1);

    // 3: 4-tick low glitch is rejected; a following 0x3C frame still decodes.
    rx8 = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    rx8 = 1'b1;
    idle_bits(2);
    chk("t3_glitch_no_done", done8, 3);
    send_frame(1'b0, 9'h03C, 8, 1'b1, 16);
    lat = cyc8_q.size() > 3 ? cyc8_q[3] - start_cyc : 0;
    chk("t3_count", done8, 4);
    chk("t3_data", data8_q.size() > 3 ? data8_q[3] : 8'hxx, 8'h3C);
    chk("t3_latency_in_window", (lat >= 604 && lat <= 616), 1'b1);
    idle_bits(1);

    // 4: low stop bit then a 20-bit break: one framing error, no re-arm during break.
    send_frame(1'b0, 9'h03C, 8, 1'b0, 16);
    chk("t4_count", done8, 5);
    chk("t4_data", data8_q.size() > 4 ? data8_q[4] : 8'hxx, 8'h3C);
    chk("t4_ferr", ferr8_q.size() > 4 ? ferr8_q[4] : 1'bx, 1'b1);
    idle_bits(20);
    chk("t4_break_no_done", done8, 5);
    rx8 = 1'b1;
    idle_bits(2);
    chk("t4_release_no_done", done8, 5);
    chk("t4_ferr_held", bus8.frameError, 1'b1);

    // 6: 7 data bits, 2 stop bits on the second receiver.
    send_frame(1'b1, 9'h055, 7, 1'b1, 32);
    lat = last_cyc7 - start_cyc;
    chk("t6_count", done7, 1);
    chk("t6_data", last_data7, 7'h55);
    chk("t6_ferr", last_ferr7, 1'b0);
    chk("t6_latency_2stop", (lat >= 604 && lat <= 616), 1'b1);
    chk("t6_other_rx_quiet", done8, 5);
    idle_bits(1);

    // 5: reset in the middle of data bit 3 of 0x5A, then receive 0x81.
    rx8 = 1'b0;
    idle_bits(1);
    rx8 = 1'b0; idle_bits(1);
    rx8 = 1'b1; idle_bits(1);
    rx8 = 1'b0; idle_bits(1);
    rx8 = 1'b1;
    repeat (BIT_CLK / 2) @(negedge clk);
    rstN = 1'b0;
    #1;
    chk("t5_reset_data8", bus8.dataOut, 8'h00);
    chk("t5_reset_ferr8", bus8.frameError, 1'b0);
    chk("t5_reset_rxdone8", bus8.rxDone, 1'b0);
    chk("t5_reset_data7", bus7.dataOut, 7'h00);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    idle_bits(2);
    chk("t5_partial_discarded", done8, 5);
    send_frame(1'b0, 9'h081, 8, 1'b1, 16);
    chk("t5_count", done8, 6);
    chk("t5_data", data8_q.size() > 5 ? data8_q[5] : 8'hxx, 8'h81);
    chk("t5_ferr", ferr8_q.size() > 5 ? ferr8_q[5] : 1'bx, 1'b0);
    idle_bits(1);

    chk("pulse_width8", wide8, 0);
    chk("pulse_width7", wide7, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive stage, directly downstream of the 16x baud-tick generator; consumes its single-cycle `baudTick` (16 ticks per bit).
Deserialises the asynchronous `rx` line, 8N1 by default, LSB first, using mid-bit sampling.
Delivers each received byte with a one-cycle `rxDone` strobe plus a framing-error flag to the core-side consumer (processor or FIFO).
The baud generator is instantiated by the parent, not inside this block.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..9).
SB_TICK, 16, baud ticks spent in the stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
clk  input  1  system clock (50 MHz).
rstN  input  1  asynchronous active-low reset; clears all state immediately when low.
baudTick  input  1  one-clk pulse at 16x baud rate, from the baud generator.
rx  input  1  serial line, idle high, asynchronous to clk.
dataOut  output  DATA_BITS  last received word; held stable until the next rxDone.
rxDone  output  1  one-clk pulse when a frame completes (good or bad).
frameError  output  1  stop bit sampled low on the last frame; valid with rxDone, held until the next rxDone.

Behaviour:
- Reset (rstN low, asynchronous):
  - state=IDLE; tick and bit counters 0; shift register 0.
  - dataOut=0, rxDone=0, frameError=0.
  - Both synchroniser flops preset to 1 (idle line), so no false start is seen on reset release.
- Input path: 2-flop synchroniser on rx → rxS. A third flop holds rxS_d for falling-edge detect.
- Counters:
  - tick: 0..15 in START/DATA, 0..SB_TICK-1 in STOP; width clog2(max(16,SB_TICK)).
  - bit: 0..DATA_BITS-1; width clog2(DATA_BITS).
  - Counters advance only on clk edges where baudTick=1.
- IDLE:
  - Waits for a falling edge on rxS (rxS_d=1, rxS=0). A line already low, e.g. a break, does not re-arm.
  - On the edge: go to START, tick=0.
- START, on each baudTick:
  - tick==7 (mid start bit), rxS==0: go to DATA, tick=0, bit=0.
  - tick==7, rxS==1: glitch/false start; return to IDLE, no rxDone.
  - otherwise: tick++.
- DATA, on each baudTick:
  - tick==15: tick=0 and shift rxS into the MSB of the shift register (right-shift, LSB first on the wire). Then, if bit==DATA_BITS-1, go to STOP; else bit++.
  - otherwise: tick++.
- STOP, on each baudTick:
  - tick==SB_TICK-1: dataOut←shift register, frameError←~rxS, rxDone←1 for exactly one clk, go to IDLE.
  - otherwise: tick++.
- Output timing:
  - rxDone, dataOut and frameError are registered and update on the same clk edge.
  - Latency: rxDone rises one clk after the baudTick that closes the stop sample, about 9.5 bit periods after the start edge for 8N1.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so a start edge arriving immediately after the stop bit is caught.
- baudTick while rxS changes: the sample uses the rxS value present on that clk edge.
- Reset mid-frame: the partial frame is discarded with no rxDone. The receiver re-arms only on a new falling edge after reset release.

Decomposition:
- Shared package uart_pkg:
  - RESOLUTION=16 (common with the baud generator).
  - State encoding IDLE/START/DATA/STOP as 2-bit localparams.
  - Default DATA_BITS/SB_TICK values.
- Sub-module uart_rx_sync: 2-flop synchroniser plus edge-detect flop, async reset to 1. Outputs rxS and fallEdge.

Test Plan:
All timings at clk 50 MHz with the real baud generator at 19200: one tick per 163 clk, bit = 2608 clk.
1. Send 0xA5 8N1 → exactly one rxDone pulse ~9.5 bits after start edge; dataOut=0xA5, frameError=0.
2. Send 0x00 then 0xFF back-to-back, no idle gap → two rxDone pulses one frame apart; dataOut 0x00 then 0xFF; frameError=0 both times.
3. rx low for 4 ticks (652 clk) then high → no rxDone; state returns to IDLE; a following 0x3C frame is received correctly.
4. Send 0x3C with stop bit driven 0, then rx held low (break) 20 bit-times, then released → one rxDone with dataOut=0x3C, frameError=1; no further rxDone during the break.
5. Assert rstN low mid-way through data bit 3 of 0x5A, release, send 0x81 → no rxDone for 0x5A; dataOut=0 right after reset; next rxDone gives 0x81.
6. DATA_BITS=7, SB_TICK=32, send 0x55 with 2 stop bits → rxDone with dataOut=7'h55; rxDone timing consistent with 2 stop bits.
